// File: rtl/memoria_pkg.sv
// memoria_pkg: shared types, constants and helpers for the memoria responder.
//   state_e        : responder FSM states (IDLE, WAIT, RESP)
//   LAT_CNT_WIDTH  : width of the wait-cycle down-counter
//   MAX_LATENCY    : largest supported LATENCY value
//   parity()       : even-parity bit of a word (zero-extend narrower words)
package memoria_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int unsigned LAT_CNT_WIDTH    = 4;
  localparam int unsigned MAX_LATENCY      = 15;
  localparam int unsigned PARITY_MAX_WIDTH = 64;

  // Even parity: the bit that makes the total count of ones even.
  // Zero-extension of narrower words does not change the result.
  function automatic logic parity(input logic [PARITY_MAX_WIDTH-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/memoria_responder_if.sv
// memoria_responder_if: request/response bus between the control unit and
// the memoria responder.
//   req, memWriteOrRead, address, dataIn : request side (control unit drives)
//   dataOut, ready, busy, parityErr       : response side (responder drives)
// Modports: master = control unit, slave = responder.
interface memoria_responder_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                  req;
  logic                  memWriteOrRead;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] dataIn;
  logic [DATA_WIDTH-1:0] dataOut;
  logic                  ready;
  logic                  busy;
  logic                  parityErr;

  modport master (
    output req, memWriteOrRead, address, dataIn,
    input  dataOut, ready, busy, parityErr
  );

  modport slave (
    input  req, memWriteOrRead, address, dataIn,
    output dataOut, ready, busy, parityErr
  );

endinterface

// File: rtl/memoria_array.sv
// memoria_array: word storage with synchronous write and combinational read.
// Contents are deliberately not reset.
//   clk         : write clock
//   we, waddr, wdata : write port, committed on the rising edge
//   raddr, rdata     : asynchronous read port
module memoria_array #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port
  assign rdata = mem[raddr];

endmodule

// File: rtl/memoria_responder.sv
// memoria_responder: word-addressed memory responder with a programmable
// number of wait cycles and a one-cycle ready pulse on completion.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : memoria_responder_if.slave (req/memWriteOrRead/address/dataIn in,
//           dataOut/ready/busy/parityErr out)
// Optional feature: define MEMORIA_PARITY_EN to store an even-parity bit per
// word and flag mismatches on reads via parityErr (tied to 0 otherwise).
module memoria_responder
  import memoria_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                clk,
  input  logic                reset,
  memoria_responder_if.slave  bus
);

  if (LATENCY == 0 || LATENCY > MAX_LATENCY) begin : g_bad_latency
    $error("memoria_responder: LATENCY %0d outside 1..%0d", LATENCY, MAX_LATENCY);
  end

`ifdef MEMORIA_PARITY_EN
  localparam int unsigned WORD_WIDTH = DATA_WIDTH + 1;
`else
  localparam int unsigned WORD_WIDTH = DATA_WIDTH;
`endif

  localparam logic [LAT_CNT_WIDTH-1:0] CNT_LOAD = LAT_CNT_WIDTH'(LATENCY - 1);

  state_e                  state_q, state_d;
  logic [LAT_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    wr_q, wr_d;
  logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
  logic                    ready_q, ready_d;
  logic                    busy_q, busy_d;

  logic                    accept_c;
  logic                    we_c;
  logic                    resp_entry_c;
  logic                    rd_resp_c;
  logic [ADDR_WIDTH-1:0]   rd_addr_c;
  logic [WORD_WIDTH-1:0]   wdata_c;
  logic [WORD_WIDTH-1:0]   rdata_c;

  // New requests are taken only when idle or in the final response cycle
  assign accept_c  = bus.req && (state_q == IDLE || state_q == RESP);
  assign we_c      = accept_c && bus.memWriteOrRead;
  // With LATENCY=1 the response is built on the accepting edge itself
  assign rd_addr_c = accept_c ? bus.address : addr_q;

`ifdef MEMORIA_PARITY_EN
  assign wdata_c = {parity(PARITY_MAX_WIDTH'(bus.dataIn)), bus.dataIn};
`else
  assign wdata_c = bus.dataIn;
`endif

  memoria_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .WIDTH      (WORD_WIDTH)
  ) u_array (
    .clk   (clk),
    .we    (we_c),
    .waddr (bus.address),
    .wdata (wdata_c),
    .raddr (rd_addr_c),
    .rdata (rdata_c)
  );

  // Next-state, counter and output computation
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wr_d         = wr_q;
    data_out_d   = data_out_q;
    resp_entry_c = 1'b0;
    rd_resp_c    = 1'b0;

    case (state_q)
      IDLE, RESP: begin
        if (accept_c) begin
          addr_d = bus.address;
          wr_d   = bus.memWriteOrRead;
          cnt_d  = CNT_LOAD;
          if (LATENCY == 1) begin
            state_d      = RESP;
            resp_entry_c = 1'b1;
            rd_resp_c    = !bus.memWriteOrRead;
          end else begin
            state_d = WAIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - LAT_CNT_WIDTH'(1);
        if (cnt_q == LAT_CNT_WIDTH'(1)) begin
          state_d      = RESP;
          resp_entry_c = 1'b1;
          rd_resp_c    = !wr_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if (rd_resp_c) begin
      data_out_d = rdata_c[DATA_WIDTH-1:0];
    end
    ready_d = resp_entry_c;
    busy_d  = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      data_out_q <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      data_out_q <= data_out_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.dataOut = data_out_q;
  assign bus.ready   = ready_q;
  assign bus.busy    = busy_q;

`ifdef MEMORIA_PARITY_EN
  logic parity_err_q, parity_err_d;

  // Parity check over the stored word, captured alongside dataOut
  always_comb begin
    parity_err_d = 1'b0;
    if (rd_resp_c) begin
      parity_err_d = parity(PARITY_MAX_WIDTH'(rdata_c[DATA_WIDTH-1:0])) != rdata_c[DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end

  assign bus.parityErr = parity_err_q;
`else
  assign bus.parityErr = 1'b0;
`endif

endmodule

// File: tb/tb_memoria_responder.sv
// tb_memoria_responder: three responders (LATENCY 2, 1, 4) share one request
// stream; a reference model predicts acceptance, memory contents and
// response timing, and a monitor checks every cycle against it.
module tb_memoria_responder;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam int          NI = 3;

`ifdef MEMORIA_PARITY_EN
  localparam bit PARITY_ON = 1'b1;
`else
  localparam bit PARITY_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          req;
  logic          wr;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;

  logic [DW-1:0] dout [NI];
  logic          rdy  [NI];
  logic          bsy  [NI];
  logic          perr [NI];

  always #5 clk = ~clk;

  function automatic int lat_of(input int i);
    case (i)
      0:       return 2;
      1:       return 1;
      default: return 4;
    endcase
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    memoria_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    assign bus.req            = req;
    assign bus.memWriteOrRead = wr;
    assign bus.address        = addr;
    assign bus.dataIn         = din;
    assign dout[g]            = bus.dataOut;
    assign rdy[g]             = bus.ready;
    assign bsy[g]             = bus.busy;
    assign perr[g]            = bus.parityErr;
    memoria_responder #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .LATENCY    (LAT)
    ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );
  end

  // Reference model state
  typedef struct {
    int          inst;
    int          due;
    bit          rd;
    logic [31:0] data;
    bit          perr;
  } exp_t;

  exp_t        sb[$];
  int          next_free [NI];
  logic [31:0] mem_m     [NI][256];
  bit          flip_m    [NI][256];
  logic [31:0] exp_dout  [NI];
  int          edge_n = 0;
  int          checks = 0;
  int          failures = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Present a request for the coming edge and predict each responder's view
  task automatic drive(input bit r, input bit w, input logic [7:0] a, input logic [31:0] d);
    int   e;
    exp_t x;
    req  = r;
    wr   = w;
    addr = a;
    din  = d;
    e    = edge_n + 1;
    if (r) begin
      for (int i = 0; i < NI; i++) begin
        if (e >= next_free[i]) begin
          if (w) begin
            mem_m[i][a]  = d;
            flip_m[i][a] = 1'b0;
          end
          x.inst = i;
          x.due  = e + lat_of(i) - 1;
          x.rd   = !w;
          x.data = mem_m[i][a];
          x.perr = PARITY_ON && flip_m[i][a];
          sb.push_back(x);
          next_free[i] = e + lat_of(i);
        end
      end
    end
  endtask

  task automatic step(input bit r, input bit w, input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    drive(r, w, a, d);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 8'h00, 32'h0);
  endtask

  // Reset for some cycles; the request given is presented as reset releases
  task automatic do_reset(input int cycles, input bit r, input bit w, input logic [7:0] a,
                          input logic [31:0] d);
    @(negedge clk);
    reset = 1'b1;
    req   = 1'b0;
    sb.delete();
    for (int i = 0; i < NI; i++) begin
      next_free[i] = 0;
      exp_dout[i]  = '0;
    end
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
    drive(r, w, a, d);
  endtask

  task automatic check_inst(input int i, input int n);
    int   idx;
    exp_t x;
    bit   exp_perr;
    idx      = -1;
    exp_perr = 1'b0;
    for (int k = 0; k < sb.size(); k++) begin
      if (sb[k].inst == i) begin
        idx = k;
        break;
      end
    end
    if (rdy[i] === 1'b1) begin
      checks++;
      if (idx < 0) begin
        failures++;
        $display("FAIL spurious_ready inst=%0d edge=%0d got ready=1 expected no response", i, n);
      end else begin
        x = sb[idx];
        sb.delete(idx);
        checks++;
        if (x.due != n) begin
          failures++;
          $display("FAIL ready_timing inst=%0d got ready at edge %0d expected edge %0d", i, n, x.due);
        end
        if (x.rd) begin
          exp_dout[i] = x.data;
          exp_perr    = x.perr;
        end
      end
    end else if (idx >= 0 && sb[idx].due <= n) begin
      checks++;
      failures++;
      $display("FAIL missing_ready inst=%0d edge=%0d got ready=%b expected 1 (due %0d)",
               i, n, rdy[i], sb[idx].due);
      sb.delete(idx);
    end
    checks++;
    if (dout[i] !== exp_dout[i]) begin
      failures++;
      $display("FAIL dataOut inst=%0d edge=%0d got %h expected %h", i, n, dout[i], exp_dout[i]);
    end
    checks++;
    if (perr[i] !== exp_perr) begin
      failures++;
      $display("FAIL parityErr inst=%0d edge=%0d got %b expected %b", i, n, perr[i], exp_perr);
    end
    checks++;
    if (bsy[i] !== (n < next_free[i])) begin
      failures++;
      $display("FAIL busy inst=%0d edge=%0d got %b expected %b", i, n, bsy[i], (n < next_free[i]));
    end
  endtask

  // Monitor: sample shortly after each rising edge
  initial begin
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < NI; i++) check_inst(i, edge_n);
    end
  end

  initial begin
    reset = 1'b1;
    req   = 1'b0;
    wr    = 1'b0;
    addr  = '0;
    din   = '0;
    for (int i = 0; i < NI; i++) begin
      next_free[i] = 0;
      exp_dout[i]  = '0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Fill every word, spaced so all latencies accept each write
    for (int a = 0; a < 256; a++) begin
      step(1'b1, 1'b1, 8'(a), $urandom);
      idle(3);
    end
    idle(2);

    step(1'b1, 1'b1, 8'h20, 32'hCAFEF00D);  idle(4);
    step(1'b1, 1'b1, 8'h05, 32'hDEADBEEF);  idle(4);
    step(1'b1, 1'b0, 8'h05, 32'h0);         idle(4);
    // Read issued in the RESP cycle of the write (LATENCY=2 instance)
    step(1'b1, 1'b1, 8'h10, 32'h12345678);  idle(1);
    step(1'b1, 1'b0, 8'h10, 32'h0);         idle(4);
    // Write presented during WAIT of a read
    step(1'b1, 1'b0, 8'h05, 32'h0);
    step(1'b1, 1'b1, 8'h20, 32'h55555555);  idle(4);
    step(1'b1, 1'b0, 8'h20, 32'h0);         idle(4);
    // Reset during WAIT of the LATENCY=4 read; request held as reset drops
    step(1'b1, 1'b0, 8'h05, 32'h0);         idle(1);
    do_reset(2, 1'b1, 1'b0, 8'h10, 32'h0);  idle(5);

`ifdef MEMORIA_PARITY_EN
    g_dut[0].dut.u_array.mem[5][0] = ~g_dut[0].dut.u_array.mem[5][0];
    mem_m[0][5][0] = ~mem_m[0][5][0];
    flip_m[0][5]   = 1'b1;
    step(1'b1, 1'b0, 8'h05, 32'h0);         idle(4);
    step(1'b1, 1'b0, 8'h10, 32'h0);         idle(4);
    step(1'b1, 1'b1, 8'h05, 32'h0BADF00D);  idle(4);
`endif

    // Randomized traffic with occasional resets
    for (int s = 0; s < 800; s++) begin
      if ($urandom_range(99) == 0) begin
        do_reset(1 + int'($urandom_range(2)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                 8'($urandom_range(255)), $urandom);
      end else begin
        step(1'($urandom_range(1)), 1'($urandom_range(1)), 8'($urandom_range(255)), $urandom);
      end
    end
    idle(8);
    @(negedge clk);

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d outstanding responses expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
